// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one uart transmitter among NREQ
// byte producers. Accepts one byte per grant and drives data_in/data_send.
// It then waits for data_sent and spends one idle cycle before re-arbitrating.
// Optional feature macro: UART_ARB_LOCK_EN (adds req_last and burst locking).
`timescale 1ns/1ps
module uart_tx_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
`ifdef UART_ARB_LOCK_EN
  input  logic [NREQ-1:0]   req_last,
`endif
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   req_done,
  output logic [7:0]        uart_data,
  output logic              uart_send,
  input  logic              uart_sent,
  output logic              busy,
  output logic [IDW-1:0]    grant_id
);

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_DONE} state_t;

  state_t          state_reg, state_next;
  logic [IDW-1:0]  last_reg, last_next;
  logic [NREQ-1:0] eligible;
  logic [IDW-1:0]  sel_id;
  logic            sel_found;

  logic [NREQ-1:0] req_ready_next, req_done_next;
  logic [7:0]      uart_data_next;
  logic            uart_send_next, busy_next;
  logic [IDW-1:0]  grant_id_next;

`ifdef UART_ARB_LOCK_EN
  logic lock_reg, lock_next;
`endif

  // While locked onto a burst only the owning requester is eligible.
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_elig
`ifdef UART_ARB_LOCK_EN
      assign eligible[gi] = req_valid[gi] & (~lock_reg | (grant_id == IDW'(gi)));
`else
      assign eligible[gi] = req_valid[gi];
`endif
    end
  endgenerate

  // Round-robin pick: first eligible requester scanning upward from last+1.
  always_comb begin
    int             scan_idx;
    logic [IDW-1:0] scan_id;
    sel_found = 1'b0;
    sel_id    = '0;
    scan_idx  = 0;
    scan_id   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      scan_idx = int'(last_reg) + k;
      if (scan_idx >= NREQ) scan_idx = scan_idx - NREQ;
      scan_id = IDW'(scan_idx);
      if (!sel_found && eligible[scan_id]) begin
        sel_found = 1'b1;
        sel_id    = scan_id;
      end
    end
  end

  // State register; reset abandons any in-flight byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= ST_IDLE;
    else      state_reg <= state_next;
  end

  // Next-state: grant in IDLE, wait for completion in SEND, one DONE cycle.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_IDLE: if (sel_found) state_next = ST_SEND;
      ST_SEND: if (uart_sent) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs and arbitration bookkeeping.
  always_comb begin
    req_ready_next = '0;
    req_done_next  = '0;
    uart_data_next = uart_data;
    uart_send_next = 1'b0;
    grant_id_next  = grant_id;
    last_next      = last_reg;
`ifdef UART_ARB_LOCK_EN
    lock_next      = lock_reg;
`endif
    unique case (state_reg)
      ST_IDLE: begin
        if (sel_found) begin
          req_ready_next[sel_id] = 1'b1;
          uart_data_next         = req_data[{sel_id, 3'b000} +: 8];
          uart_send_next         = 1'b1;
          grant_id_next          = sel_id;
`ifdef UART_ARB_LOCK_EN
          lock_next              = ~req_last[sel_id];
`endif
        end
      end
      ST_SEND: begin
        // Drop data_send in the DONE cycle so a level-sensitive uart cannot resend.
        uart_send_next = ~uart_sent;
        if (uart_sent) req_done_next[grant_id] = 1'b1;
      end
      ST_DONE: begin
        last_next = grant_id;
      end
      default: ;
    endcase
    busy_next = (state_next != ST_IDLE);
  end

  // Output and bookkeeping registers; last starts at NREQ-1 so requester 0 wins first.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_ready <= '0;
      req_done  <= '0;
      uart_data <= '0;
      uart_send <= 1'b0;
      busy      <= 1'b0;
      grant_id  <= '0;
      last_reg  <= IDW'(NREQ - 1);
`ifdef UART_ARB_LOCK_EN
      lock_reg  <= 1'b0;
`endif
    end else begin
      req_ready <= req_ready_next;
      req_done  <= req_done_next;
      uart_data <= uart_data_next;
      uart_send <= uart_send_next;
      busy      <= busy_next;
      grant_id  <= grant_id_next;
      last_reg  <= last_next;
`ifdef UART_ARB_LOCK_EN
      lock_reg  <= lock_next;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: the stimulus pushes expected grants into a
// scoreboard, and a monitor pops and compares them on every req_ready and req_done.
// The lock-order expectations follow UART_ARB_LOCK_EN.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk, rst;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
`ifdef UART_ARB_LOCK_EN
  logic [NREQ-1:0]   req_last;
`endif
  logic [NREQ-1:0]   req_ready, req_done;
  logic [7:0]        uart_data;
  logic              uart_send, uart_sent, busy;
  logic [IDW-1:0]    grant_id;

  uart_tx_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
`ifdef UART_ARB_LOCK_EN
    .req_last(req_last),
`endif
    .req_ready(req_ready), .req_done(req_done), .uart_data(uart_data),
    .uart_send(uart_send), .uart_sent(uart_sent), .busy(busy), .grant_id(grant_id)
  );

  typedef struct { int id; logic [7:0] data; } exp_t;
  exp_t exp_q[$];
  int   done_q[$];

  int n_checks = 0, n_pass = 0;
  int done_count = 0, cyc = 0;
  int gap_from_cyc = 0, prev_done_cyc = -1;
  bit gap_chk_en = 0;

  int         rem[NREQ], sent[NREQ];
  logic [7:0] base[NREQ];
  bit         burst[NREQ];
  bit stub_en = 0;
  int stub_delay = 5, stub_hold = 1, stub_cnt = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
  endtask

  task automatic push(input int id, input logic [7:0] d);
    exp_t e;
    e.id = id; e.data = d;
    exp_q.push_back(e);
  endtask

  // Monitor: compares every accepted byte and every completion against the scoreboard.
  initial forever begin
    int   idx;
    exp_t e;
    @(negedge clk);
    if (!rst) begin
      done_q.delete();
    end else begin
      if (req_ready != '0) begin
        idx = -1;
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) idx = i;
        check("ready_onehot", 32'($onehot(req_ready)), 1);
        if (exp_q.size() == 0) begin
          check("unexpected_ready", 32'(req_ready), 0);
        end else begin
          e = exp_q.pop_front();
          $display("grant: id=%0d data=0x%02h (expected id=%0d data=0x%02h) cycle=%0d",
                   idx, uart_data, e.id, e.data, cyc);
          check("ready_id", idx, e.id);
          check("grant_id", 32'(grant_id), e.id);
          check("uart_data", 32'(uart_data), 32'(e.data));
          check("uart_send_at_ready", 32'(uart_send), 1);
          check("busy_at_ready", 32'(busy), 1);
          if (gap_chk_en && prev_done_cyc >= gap_from_cyc)
            check("done_to_ready_gap", cyc - prev_done_cyc, 2);
          done_q.push_back(e.id);
        end
      end
      if (req_done != '0) begin
        idx = -1;
        for (int i = 0; i < NREQ; i++) if (req_done[i]) idx = i;
        done_count++;
        prev_done_cyc = cyc;
        $display("done: id=%0d cycle=%0d", idx, cyc);
        if (done_q.size() == 0) check("unexpected_done", 32'(req_done), 0);
        else check("done_id", idx, done_q.pop_front());
        check("uart_send_low_in_done", 32'(uart_send), 0);
      end
    end
  end

  task automatic drive_byte(input int i);
    req_data[8*i +: 8] = 8'(base[i] + 8'(8'h40 * sent[i]));
`ifdef UART_ARB_LOCK_EN
    req_last[i] = burst[i] ? (rem[i] <= 1) : 1'b1;
`endif
  endtask

  task automatic start_req(input int i, input int n, input logic [7:0] b, input bit bur);
    base[i] = b; sent[i] = 0; rem[i] = n; burst[i] = bur;
    drive_byte(i);
    req_valid[i] = 1'b1;
  endtask

  // One clock of requester and uart-stub behaviour; all inputs are driven from here.
  task automatic step();
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      if (rst && req_valid[i] && req_ready[i]) begin
        sent[i]++;
        rem[i]--;
        if (rem[i] == 0) req_valid[i] = 1'b0;
        drive_byte(i);
      end
    end
    if (stub_en) begin
      if (!rst) begin
        stub_cnt = 0; uart_sent = 1'b0;
      end else if (stub_cnt == 0) begin
        uart_sent = 1'b0;
        if (uart_send) stub_cnt = stub_delay + stub_hold;
      end else begin
        stub_cnt--;
        uart_sent = (stub_cnt < stub_hold);
      end
    end
  endtask

  task automatic wait_done(input int target, input int budget, input string name);
    for (int k = 0; k < budget && done_count < target; k++) step();
    check(name, done_count, target);
  endtask

  initial begin
    int d0;
    rst = 1'b0; uart_sent = 1'b0; req_valid = '0; req_data = '0;
`ifdef UART_ARB_LOCK_EN
    req_last = '1;
`endif
    for (int i = 0; i < NREQ; i++) begin rem[i] = 0; sent[i] = 0; base[i] = '0; burst[i] = 0; end

    // Reset held 10 cycles with a spurious completion in the middle.
    for (int k = 0; k < 10; k++) begin
      step();
      uart_sent = (k >= 3 && k < 7);
    end
    uart_sent = 1'b0;
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_req_done", 32'(req_done), 0);
    check("rst_uart_data", 32'(uart_data), 0);
    check("rst_uart_send", 32'(uart_send), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_grant_id", 32'(grant_id), 0);
    rst = 1'b1;
    repeat (3) step();
    check("post_rst_busy", 32'(busy), 0);

    // Fairness: all four valid, accepted order 0,1,2,3,0,1 with a 2-cycle done->ready gap.
    stub_en = 1; stub_delay = 5; stub_hold = 1;
    gap_from_cyc = cyc; gap_chk_en = 1;
    start_req(0, 2, 8'h10, 0); start_req(1, 2, 8'h11, 0);
    start_req(2, 1, 8'h12, 0); start_req(3, 1, 8'h13, 0);
    push(0, 8'h10); push(1, 8'h11); push(2, 8'h12); push(3, 8'h13);
    push(0, 8'h50); push(1, 8'h51);
    wait_done(6, 2000, "fair_done_count");
    gap_chk_en = 0;
    repeat (3) step();

    // Single byte from requester 2 with a long frame time.
    stub_delay = 217;
    start_req(2, 1, 8'hA5, 0);
    push(2, 8'hA5);
    step();
    check("single_ready_latency", 32'(req_ready), 32'h4);
    check("single_uart_send", 32'(uart_send), 1);
    wait_done(7, 600, "single_done_count");
    step();
    check("single_busy_after", 32'(busy), 0);

    // Spurious completion in IDLE with no requests.
    repeat (2) step();
    stub_en = 0;
    uart_sent = 1'b1;
    step();
    uart_sent = 1'b0;
    repeat (3) step();
    check("spur_idle_busy", 32'(busy), 0);
    check("spur_idle_send", 32'(uart_send), 0);
    check("spur_idle_done", done_count, 7);

    // Completion held high 3 cycles: exactly one req_done.
    stub_en = 1; stub_delay = 10; stub_hold = 3;
    start_req(0, 1, 8'h3C, 0);
    push(0, 8'h3C);
    wait_done(8, 200, "hold3_done");
    repeat (6) step();
    check("hold3_single_done", done_count, 8);

    // Burst: requester 1 sends 3 bytes while requester 0 is continuously valid.
    stub_hold = 1; stub_delay = 5;
    start_req(1, 3, 8'h21, 1); start_req(0, 2, 8'h30, 0);
`ifdef UART_ARB_LOCK_EN
    push(1, 8'h21); push(1, 8'h61); push(1, 8'hA1); push(0, 8'h30); push(0, 8'h70);
`else
    push(1, 8'h21); push(0, 8'h30); push(1, 8'h61); push(0, 8'h70); push(1, 8'hA1);
`endif
    wait_done(13, 3000, "burst_done_count");
    repeat (3) step();

    // Asynchronous reset 50 cycles into SEND abandons the byte.
    stub_delay = 200;
    start_req(3, 1, 8'h77, 0);
    push(3, 8'h77);
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) step();
    check("rstmid_accepted", exp_q.size(), 0);
    repeat (50) step();
    check("rstmid_send_before", 32'(uart_send), 1);
    d0 = done_count;
    #2 rst = 1'b0;
    #1;
    check("rstmid_send_async", 32'(uart_send), 0);
    check("rstmid_busy_async", 32'(busy), 0);
    check("rstmid_data_async", 32'(uart_data), 0);
    repeat (5) step();
    check("rstmid_no_done", done_count, d0);
    rst = 1'b1;
    start_req(0, 1, 8'h0A, 0); start_req(3, 1, 8'h3A, 0);
    push(0, 8'h0A); push(3, 8'h3A);
    stub_delay = 5;
    wait_done(d0 + 2, 500, "rstmid_after_done");
    repeat (3) step();

    check("scoreboard_empty", exp_q.size(), 0);
    check("done_queue_empty", done_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
